// File: rtl/cvxif_result_scheduler.sv
// CV-X-IF result scheduler: buffers ALU results until their id commits, drops killed ones,
// and hands out issue credits. Optional same-cycle bypass under `CVXIF_RESULT_BYPASS_EN`.
module cvxif_result_scheduler #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned ID_WIDTH     = 3,
   parameter int unsigned HARTID_WIDTH = 1,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    issue_accept_i,
   output logic                    issue_allow_o,
   input  logic                    alu_valid_i,
   input  logic [HARTID_WIDTH-1:0] alu_hartid_i,
   input  logic [ID_WIDTH-1:0]     alu_id_i,
   input  logic [4:0]              alu_rd_i,
   input  logic                    alu_we_i,
   input  logic [XLEN-1:0]         alu_data_i,
   input  logic                    commit_valid_i,
   input  logic [ID_WIDTH-1:0]     commit_id_i,
   input  logic                    commit_kill_i,
   output logic                    result_valid_o,
   input  logic                    result_ready_i,
   output logic [HARTID_WIDTH-1:0] result_hartid_o,
   output logic [ID_WIDTH-1:0]     result_id_o,
   output logic [4:0]              result_rd_o,
   output logic                    result_we_o,
   output logic [XLEN-1:0]         result_data_o,
   output logic                    overflow_o
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned NID = 1 << ID_WIDTH;

   typedef enum logic [1:0] {
      HEAD_EMPTY,
      HEAD_WAIT,
      HEAD_READY,
      HEAD_KILL
   } head_e;

   logic [HARTID_WIDTH-1:0] r_hartid [DEPTH];
   logic [ID_WIDTH-1:0]     r_id     [DEPTH];
   logic [4:0]              r_rd     [DEPTH];
   logic                    r_we     [DEPTH];
   logic [XLEN-1:0]         r_data   [DEPTH];

   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  r_outstanding;
   logic [NID-1:0] r_committed;
   logic [NID-1:0] r_killed;
   logic           r_overflow;

   head_e                   w_head;
   logic [ID_WIDTH-1:0]     w_head_id;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_handshake;
   logic                    w_discard;
   logic                    w_fifo_pop;
   logic                    w_bypass_take;
   logic                    w_push;
   logic                    w_overflow_evt;
   logic                    w_credit_ret;
   logic                    w_clr_en;
   logic [ID_WIDTH-1:0]     w_clr_id;
   logic                    w_set_en;
   logic [CW-1:0]           w_count_nxt;
   logic [CW-1:0]           w_outstanding_nxt;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_head_id = r_id[r_rptr];

   // Killed entries always carry committed=1, so kill takes priority in the classification.
   always_comb begin
      w_head = HEAD_EMPTY;
      if (!w_empty) begin
         if (r_committed[w_head_id] && r_killed[w_head_id]) begin
            w_head = HEAD_KILL;
         end else if (r_committed[w_head_id]) begin
            w_head = HEAD_READY;
         end else begin
            w_head = HEAD_WAIT;
         end
      end
   end

`ifdef CVXIF_RESULT_BYPASS_EN
   logic w_bypass;
   assign w_bypass      = w_empty && alu_valid_i && r_committed[alu_id_i] && !r_killed[alu_id_i];
   assign w_bypass_take = w_bypass && result_ready_i;
`else
   assign w_bypass_take = 1'b0;
`endif

   always_comb begin
      result_valid_o  = 1'b0;
      result_hartid_o = '0;
      result_id_o     = '0;
      result_rd_o     = '0;
      result_we_o     = 1'b0;
      result_data_o   = '0;
      if (!w_empty) begin
         result_valid_o  = (w_head == HEAD_READY);
         result_hartid_o = r_hartid[r_rptr];
         result_id_o     = w_head_id;
         result_rd_o     = r_rd[r_rptr];
         result_we_o     = r_we[r_rptr];
         result_data_o   = r_data[r_rptr];
      end
`ifdef CVXIF_RESULT_BYPASS_EN
      else if (w_bypass) begin
         result_valid_o  = 1'b1;
         result_hartid_o = alu_hartid_i;
         result_id_o     = alu_id_i;
         result_rd_o     = alu_rd_i;
         result_we_o     = alu_we_i;
         result_data_o   = alu_data_i;
      end
`endif
   end

   assign w_handshake    = (w_head == HEAD_READY) && result_ready_i;
   assign w_discard      = (w_head == HEAD_KILL);
   assign w_fifo_pop     = w_handshake || w_discard;
   assign w_push         = alu_valid_i && !w_bypass_take && (!w_full || w_fifo_pop);
   assign w_overflow_evt = alu_valid_i && !w_bypass_take && w_full && !w_fifo_pop;
   assign w_credit_ret   = w_fifo_pop || w_bypass_take;
   assign w_clr_en       = w_fifo_pop || w_bypass_take;
   assign w_clr_id       = w_fifo_pop ? w_head_id : alu_id_i;

   // A commit for an id being freed this cycle belongs to the next instruction reusing that id,
   // so it bypasses the first-event-wins check and overrides the clear.
   assign w_set_en = commit_valid_i &&
                     (!r_committed[commit_id_i] || (w_clr_en && (w_clr_id == commit_id_i)));

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_fifo_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_fifo_pop && !w_push) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_comb begin
      w_outstanding_nxt = r_outstanding;
      if (issue_accept_i && !w_credit_ret) begin
         w_outstanding_nxt = r_outstanding + CW'(1);
      end else if (w_credit_ret && !issue_accept_i) begin
         w_outstanding_nxt = r_outstanding - CW'(1);
      end
   end

   assign issue_allow_o = (r_outstanding < CW'(DEPTH));
   assign overflow_o    = r_overflow;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_committed   <= '0;
         r_killed      <= '0;
         r_overflow    <= 1'b0;
      end else begin
         r_count       <= w_count_nxt;
         r_outstanding <= w_outstanding_nxt;
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_fifo_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_overflow_evt) begin
            r_overflow <= 1'b1;
         end
         if (w_clr_en) begin
            r_committed[w_clr_id] <= 1'b0;
            r_killed[w_clr_id]    <= 1'b0;
         end
         if (w_set_en) begin
            r_committed[commit_id_i] <= 1'b1;
            r_killed[commit_id_i]    <= commit_kill_i;
         end
      end
   end

   // Payload storage needs no reset: it is only observed when the count says it is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_hartid[r_wptr] <= alu_hartid_i;
         r_id[r_wptr]     <= alu_id_i;
         r_rd[r_wptr]     <= alu_rd_i;
         r_we[r_wptr]     <= alu_we_i;
         r_data[r_wptr]   <= alu_data_i;
      end
   end

endmodule

// File: tb/tb_cvxif_result_scheduler.sv
// Directed, table-driven bench for cvxif_result_scheduler (default build, DEPTH=4, ID_WIDTH=3).
module tb_cvxif_result_scheduler;

   logic        clk;
   logic        rst_n;
   logic        issue_accept;
   logic        issue_allow;
   logic        alu_valid;
   logic [0:0]  alu_hartid;
   logic [2:0]  alu_id;
   logic [4:0]  alu_rd;
   logic        alu_we;
   logic [31:0] alu_data;
   logic        commit_valid;
   logic [2:0]  commit_id;
   logic        commit_kill;
   logic        result_valid;
   logic        result_ready;
   logic [0:0]  result_hartid;
   logic [2:0]  result_id;
   logic [4:0]  result_rd;
   logic        result_we;
   logic [31:0] result_data;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   cvxif_result_scheduler #(
      .XLEN(32),
      .ID_WIDTH(3),
      .HARTID_WIDTH(1),
      .DEPTH(4)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .issue_accept_i  (issue_accept),
      .issue_allow_o   (issue_allow),
      .alu_valid_i     (alu_valid),
      .alu_hartid_i    (alu_hartid),
      .alu_id_i        (alu_id),
      .alu_rd_i        (alu_rd),
      .alu_we_i        (alu_we),
      .alu_data_i      (alu_data),
      .commit_valid_i  (commit_valid),
      .commit_id_i     (commit_id),
      .commit_kill_i   (commit_kill),
      .result_valid_o  (result_valid),
      .result_ready_i  (result_ready),
      .result_hartid_o (result_hartid),
      .result_id_o     (result_id),
      .result_rd_o     (result_rd),
      .result_we_o     (result_we),
      .result_data_o   (result_data),
      .overflow_o      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        acc;
      logic        av;
      logic [2:0]  aid;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        cv;
      logic [2:0]  cid;
      logic        ck;
      logic        rdy;
      logic        ev;
      logic [2:0]  eid;
      logic [4:0]  erd;
      logic [31:0] edata;
      logic        eallow;
      logic        eovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic acc, logic av, logic [2:0] aid, logic [4:0] ard,
                               logic [31:0] adata, logic cv, logic [2:0] cid, logic ck, logic rdy,
                               logic ev, logic [2:0] eid, logic [4:0] erd, logic [31:0] edata,
                               logic eallow, logic eovf);
      vec_t v;
      v.rst_n = r;   v.acc = acc;   v.av = av;     v.aid = aid;   v.ard = ard;
      v.adata = adata; v.cv = cv;   v.cid = cid;   v.ck = ck;     v.rdy = rdy;
      v.ev = ev;     v.eid = eid;   v.erd = erd;   v.edata = edata;
      v.eallow = eallow; v.eovf = eovf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n        = v.rst_n;
      issue_accept = v.acc;
      alu_valid    = v.av;
      alu_hartid   = 1'b1;
      alu_id       = v.aid;
      alu_rd       = v.ard;
      alu_we       = 1'b1;
      alu_data     = v.adata;
      commit_valid = v.cv;
      commit_id    = v.cid;
      commit_kill  = v.ck;
      result_ready = v.rdy;
   endtask

   task automatic apply(input int idx, input vec_t v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      check($sformatf("row%0d valid", idx), {31'd0, result_valid}, {31'd0, v.ev});
      check($sformatf("row%0d allow", idx), {31'd0, issue_allow}, {31'd0, v.eallow});
      check($sformatf("row%0d overflow", idx), {31'd0, overflow}, {31'd0, v.eovf});
      if (v.ev) begin
         check($sformatf("row%0d id", idx), {29'd0, result_id}, {29'd0, v.eid});
         check($sformatf("row%0d rd", idx), {27'd0, result_rd}, {27'd0, v.erd});
         check($sformatf("row%0d data", idx), result_data, v.edata);
         check($sformatf("row%0d we", idx), {31'd0, result_we}, 32'd1);
         check($sformatf("row%0d hartid", idx), {31'd0, result_hartid}, 32'd1);
      end else if (!v.rst_n) begin
         check($sformatf("row%0d data_zero", idx), result_data, 32'd0);
         check($sformatf("row%0d rd_zero", idx), {27'd0, result_rd}, 32'd0);
      end
   endtask

   initial begin
      vec_t idle;
      idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      drive(idle);
      rst_n = 1'b0;

      //          rst acc av aid rd  adata          cv cid ck rdy  ev eid rd  edata         allow ovf
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0,   0, 0, 0, 32'h0,          1, 0));
      // committed before push: valid one cycle after the push
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 2, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 1, 2, 5, 32'hDEADBEEF,   0, 0, 0, 1,   1, 2, 5, 32'hDEADBEEF,   1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      // uncommitted head waits, then commit -> valid next cycle
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 1, 1, 3, 32'h11,         0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      for (int i = 0; i < 4; i++) tbl.push_back(idle);
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          1, 1, 0, 1,   1, 1, 3, 32'h11,         1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      // killed head discarded silently, younger committed entry presented
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 1, 1, 3, 4, 32'h33,         0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 1, 4, 6, 32'h44,         0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          1, 3, 1, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          1, 4, 0, 1,   1, 4, 6, 32'h44,         1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      // four credits consumed -> allow drops
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 5, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 6, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 7, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          1, 0, 0, 1,   0, 0, 0, 32'h0,          0, 0));
      // fill with ready low; head must stay stable
      tbl.push_back(mk(1, 0, 1, 5, 1, 32'h55,         0, 0, 0, 0,   1, 5, 1, 32'h55,         0, 0));
      tbl.push_back(mk(1, 0, 1, 6, 2, 32'h66,         0, 0, 0, 0,   1, 5, 1, 32'h55,         0, 0));
      tbl.push_back(mk(1, 0, 1, 7, 3, 32'h77,         0, 0, 0, 0,   1, 5, 1, 32'h55,         0, 0));
      tbl.push_back(mk(1, 0, 1, 0, 4, 32'h80,         0, 0, 0, 0,   1, 5, 1, 32'h55,         0, 0));
      // full: pop and push in the same cycle is accepted
      tbl.push_back(mk(1, 0, 1, 1, 5, 32'h91,         0, 0, 0, 1,   1, 6, 2, 32'h66,         1, 0));
      // still full, no pop: push dropped, overflow sticky
      tbl.push_back(mk(1, 0, 1, 2, 6, 32'hA2,         0, 0, 0, 0,   1, 6, 2, 32'h66,         1, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0,   1, 6, 2, 32'h66,         1, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1,   1, 7, 3, 32'h77,         1, 1));
      // reset with three entries queued; status table must be cleared
      tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 1, 1, 7, 2, 32'h70,         0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          1, 7, 0, 1,   1, 7, 2, 32'h70,         1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 1,   0, 0, 0, 32'h0,          1, 0));

      foreach (tbl[i]) apply(i, tbl[i]);

      // Streaming sequence: ids 0..7,0,1 one per cycle, wrapping both pointers.
      for (int k = 0; k < 10; k++) begin
         vec_t v;
         logic [2:0] id;
         id = 3'(k % 8);
         v = mk(1, 1, 1, id, 5'(k), 32'hC0DE_0000 + 32'(k), 1, id, 0, 1,
                1, id, 5'(k), 32'hC0DE_0000 + 32'(k), 1, 0);
         apply(100 + k, v);
      end
      apply(110, idle);

      // Hand-written: commit and kill of the same id in consecutive cycles, first event wins.
      @(negedge clk);
      drive(idle);
      issue_accept = 1'b1;
      commit_valid = 1'b1; commit_id = 3'd3; commit_kill = 1'b0;
      @(negedge clk);
      issue_accept = 1'b0;
      commit_kill  = 1'b1;
      alu_valid = 1'b1; alu_id = 3'd3; alu_rd = 5'd9; alu_data = 32'h0BAD_F00D;
      @(negedge clk);
      drive(idle);
      check("first_event_valid", {31'd0, result_valid}, 32'd1);
      check("first_event_data", result_data, 32'h0BAD_F00D);
      @(posedge clk);
      #1;
      check("first_event_popped", {31'd0, result_valid}, 32'd0);
      check("first_event_allow", {31'd0, issue_allow}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
